// File: rtl/imem_loader_if.sv
// Bus bundle for imem_loader: program load port, fetch port and status outputs.
// A load word transfers on a clock edge where load_valid and load_ready are both high; fetch_req has no ready.
interface imem_loader_if #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 32,
    parameter int LW       = 7
) ();
    logic                load_start;
    logic                load_valid;
    logic [WIDTH-1:0]    load_data;
    logic                load_ready;
    logic                load_done;
    logic                fetch_req;
    logic [PC_WIDTH-1:0] pc;
    logic                stall;
    logic [WIDTH-1:0]    instr;
    logic                instr_valid;
    logic                oob;
    logic                misaligned;
    logic [LW-1:0]       prog_len;
    logic                load_overflow;
    logic [1:0]          state_dbg;

    modport master (
        output load_start, load_valid, load_data, load_done, fetch_req, pc, stall,
        input  load_ready, instr, instr_valid, oob, misaligned, prog_len, load_overflow, state_dbg
    );

    modport slave (
        input  load_start, load_valid, load_data, load_done, fetch_req, pc, stall,
        output load_ready, instr, instr_valid, oob, misaligned, prog_len, load_overflow, state_dbg
    );
endinterface

// File: rtl/imem_loader.sv
// Runtime-loadable instruction memory: filled through a valid/ready load port,
// then serves registered fetches by PC; anything beyond the loaded length reads as NOP.
module imem_loader #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 64,
    parameter int               PC_WIDTH  = 32,
    parameter int               BYTE_ADDR = 0,
    parameter logic [WIDTH-1:0] NOP       = '0
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [LW-1:0]       wr_ptr;
    logic [LW-1:0]       prog_len_q;
    logic                overflow_q;
    logic [WIDTH-1:0]    instr_q;
    logic                instr_valid_q;
    logic                oob_q;
    logic                mis_q;

    logic                wr_en;
    logic [PC_WIDTH-1:0] idx;
    logic                fetch_mis;
    logic                fetch_oob;
    logic [WIDTH-1:0]    rd_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    // load_start wins over load_done, so a restart never slips into RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (bus.load_start) state_d = S_LOAD;
            S_LOAD: begin
                if (bus.load_start)     state_d = S_LOAD;
                else if (bus.load_done) state_d = S_RUN;
            end
            S_RUN:   if (bus.load_start) state_d = S_LOAD;
            default: state_d = S_EMPTY;
        endcase
    end

    assign bus.load_ready = (state_q == S_LOAD) && (wr_ptr < LW'(DEPTH));
    assign wr_en          = (state_q == S_LOAD) && !bus.load_start &&
                            bus.load_valid && bus.load_ready;

    always_comb begin
        idx       = (BYTE_ADDR != 0) ? (bus.pc >> 2) : bus.pc;
        fetch_mis = (BYTE_ADDR != 0) && (bus.pc[1:0] != 2'b00);
        // Full-width compare: any set upper PC bit lands out of range.
        fetch_oob = idx >= PC_WIDTH'(prog_len_q);
        rd_word   = mem[idx[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            prog_len_q    <= '0;
            overflow_q    <= 1'b0;
            instr_q       <= NOP;
            instr_valid_q <= 1'b0;
            oob_q         <= 1'b0;
            mis_q         <= 1'b0;
        end else if (bus.load_start) begin
            wr_ptr        <= '0;
            prog_len_q    <= '0;
            overflow_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            oob_q         <= 1'b0;
            mis_q         <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (wr_en) begin
                        wr_ptr     <= wr_ptr + LW'(1);
                        prog_len_q <= wr_ptr + LW'(1);
                    end else if (bus.load_valid && (wr_ptr == LW'(DEPTH))) begin
                        overflow_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        if (bus.fetch_req) begin
                            instr_valid_q <= 1'b1;
                            if (fetch_mis) begin
                                instr_q <= NOP;
                                mis_q   <= 1'b1;
                                oob_q   <= 1'b0;
                            end else if (fetch_oob) begin
                                instr_q <= NOP;
                                mis_q   <= 1'b0;
                                oob_q   <= 1'b1;
                            end else begin
                                instr_q <= rd_word;
                                mis_q   <= 1'b0;
                                oob_q   <= 1'b0;
                            end
                        end else begin
                            instr_valid_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr         = instr_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.oob           = oob_q;
    assign bus.misaligned    = mis_q;
    assign bus.prog_len      = prog_len_q;
    assign bus.load_overflow = overflow_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a word-indexed DEPTH=64 instance, a DEPTH=4
// instance for the full/overflow path, and a byte-addressed instance.
module tb_imem_loader;
    localparam logic [31:0] MAIN_NOP = 32'h0000_0013;
    localparam int ST_EMPTY = 0;
    localparam int ST_LOAD  = 1;
    localparam int ST_RUN   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_done = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] pc = '0;
    logic        stall = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.WIDTH(32), .PC_WIDTH(32), .LW(7)) m_if ();
    imem_loader_if #(.WIDTH(32), .PC_WIDTH(32), .LW(3)) s_if ();
    imem_loader_if #(.WIDTH(32), .PC_WIDTH(32), .LW(4)) b_if ();

    // Control strobes reach only the selected instance; data/pc are shared.
    assign m_if.load_start = load_start & (sel == 2'd0);
    assign m_if.load_valid = load_valid & (sel == 2'd0);
    assign m_if.load_done  = load_done  & (sel == 2'd0);
    assign m_if.fetch_req  = fetch_req  & (sel == 2'd0);
    assign m_if.stall      = stall      & (sel == 2'd0);
    assign m_if.load_data  = load_data;
    assign m_if.pc         = pc;

    assign s_if.load_start = load_start & (sel == 2'd1);
    assign s_if.load_valid = load_valid & (sel == 2'd1);
    assign s_if.load_done  = load_done  & (sel == 2'd1);
    assign s_if.fetch_req  = fetch_req  & (sel == 2'd1);
    assign s_if.stall      = stall      & (sel == 2'd1);
    assign s_if.load_data  = load_data;
    assign s_if.pc         = pc;

    assign b_if.load_start = load_start & (sel == 2'd2);
    assign b_if.load_valid = load_valid & (sel == 2'd2);
    assign b_if.load_done  = load_done  & (sel == 2'd2);
    assign b_if.fetch_req  = fetch_req  & (sel == 2'd2);
    assign b_if.stall      = stall      & (sel == 2'd2);
    assign b_if.load_data  = load_data;
    assign b_if.pc         = pc;

    imem_loader #(.WIDTH(32), .DEPTH(64), .PC_WIDTH(32), .BYTE_ADDR(0), .NOP(MAIN_NOP))
        u_main (.clk(clk), .reset(reset), .bus(m_if));
    imem_loader #(.WIDTH(32), .DEPTH(4), .PC_WIDTH(32), .BYTE_ADDR(0), .NOP(32'h0))
        u_small (.clk(clk), .reset(reset), .bus(s_if));
    imem_loader #(.WIDTH(32), .DEPTH(8), .PC_WIDTH(32), .BYTE_ADDR(1), .NOP(32'h0))
        u_byte (.clk(clk), .reset(reset), .bus(b_if));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        chk("rst_instr",    m_if.instr, MAIN_NOP);
        chk("rst_valid",    m_if.instr_valid, 0);
        chk("rst_prog_len", m_if.prog_len, 0);
        chk("rst_ready",    m_if.load_ready, 0);
        chk("rst_oob",      m_if.oob, 0);
        chk("rst_mis",      m_if.misaligned, 0);
        chk("rst_ovf",      m_if.load_overflow, 0);
        chk("rst_state",    m_if.state_dbg, ST_EMPTY);
        chk("rst_s_ready",  s_if.load_ready, 0);
        reset = 1'b0;

        // EMPTY ignores everything except load_start
        load_valid = 1'b1; load_data = 32'hDEAD_0000; fetch_req = 1'b1;
        tick();
        load_valid = 1'b0; fetch_req = 1'b0;
        chk("empty_state", m_if.state_dbg, ST_EMPTY);
        chk("empty_len",   m_if.prog_len, 0);

        // 22-word load then sequential fetch
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("load_state", m_if.state_dbg, ST_LOAD);
        chk("load_ready", m_if.load_ready, 1);
        for (int i = 0; i < 22; i++) begin
            load_valid = 1'b1; load_data = 32'h0000_1000 + i;
            tick();
        end
        load_valid = 1'b0;
        chk("len22", m_if.prog_len, 22);
        fetch_req = 1'b1; pc = 0;
        tick();
        chk("load_fetch_ignored", m_if.instr_valid, 0);
        fetch_req = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        chk("run_state", m_if.state_dbg, ST_RUN);
        chk("run_ready", m_if.load_ready, 0);
        for (int i = 0; i < 22; i++) begin
            fetch_req = 1'b1; pc = i;
            tick();
            chk("seq_instr", m_if.instr, 32'h0000_1000 + i);
            chk("seq_valid", m_if.instr_valid, 1);
            chk("seq_oob",   m_if.oob, 0);
        end

        // out of range
        pc = 22; tick();
        chk("oob22_instr", m_if.instr, MAIN_NOP);
        chk("oob22_oob",   m_if.oob, 1);
        chk("oob22_valid", m_if.instr_valid, 1);
        pc = 32'h8000_0000; tick();
        chk("oobhi_instr", m_if.instr, MAIN_NOP);
        chk("oobhi_oob",   m_if.oob, 1);
        chk("oobhi_valid", m_if.instr_valid, 1);

        // stall and gaps
        pc = 3; tick();
        chk("st_pre_instr", m_if.instr, 32'h0000_1003);
        chk("st_pre_oob",   m_if.oob, 0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc = 5 + 2 * k;
            tick();
            chk("stall_instr", m_if.instr, 32'h0000_1003);
            chk("stall_valid", m_if.instr_valid, 1);
        end
        stall = 1'b0; fetch_req = 1'b0; tick();
        chk("gap_valid", m_if.instr_valid, 0);
        chk("gap_instr", m_if.instr, 32'h0000_1003);

        // RUN -> LOAD clears status; beat together with load_done is written
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("reload_state", m_if.state_dbg, ST_LOAD);
        chk("reload_len",   m_if.prog_len, 0);
        load_valid = 1'b1; load_data = 32'hAAAA_0001; tick();
        load_data = 32'hAAAA_0002; load_done = 1'b1; tick();
        load_valid = 1'b0; load_done = 1'b0;
        chk("vd_state", m_if.state_dbg, ST_RUN);
        chk("vd_len",   m_if.prog_len, 2);
        fetch_req = 1'b1; pc = 1; tick();
        chk("vd_instr", m_if.instr, 32'hAAAA_0002);
        pc = 2; tick();
        chk("vd_oob", m_if.oob, 1);
        fetch_req = 1'b0;

        // load_start beats load_done
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_valid = 1'b1; load_data = 32'h5555_0000; tick(); load_valid = 1'b0;
        chk("sd_len_pre", m_if.prog_len, 1);
        load_start = 1'b1; load_done = 1'b1; tick();
        load_start = 1'b0; load_done = 1'b0;
        chk("sd_state", m_if.state_dbg, ST_LOAD);
        chk("sd_len",   m_if.prog_len, 0);

        // zero-word program: every fetch is OOB
        load_done = 1'b1; tick(); load_done = 1'b0;
        chk("zero_state", m_if.state_dbg, ST_RUN);
        fetch_req = 1'b1; pc = 0; tick(); fetch_req = 1'b0;
        chk("zero_oob",   m_if.oob, 1);
        chk("zero_instr", m_if.instr, MAIN_NOP);

        // DEPTH=4: full and overflow
        sel = 2'd1;
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1; load_data = 32'hC000_0000 + i;
            #1;
            chk("full_ready", s_if.load_ready, (i < 4) ? 1 : 0);
            tick();
            if (i == 3) chk("full_ovf_pre", s_if.load_overflow, 0);
        end
        load_valid = 1'b0;
        chk("full_ovf", s_if.load_overflow, 1);
        chk("full_len", s_if.prog_len, 4);
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("restart_ovf",   s_if.load_overflow, 0);
        chk("restart_len",   s_if.prog_len, 0);
        chk("restart_ready", s_if.load_ready, 1);

        // byte-addressed instance
        sel = 2'd2;
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = 32'hB000_0000 + i;
            tick();
        end
        load_valid = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        fetch_req = 1'b1;
        pc = 8; tick();
        chk("ba8_instr", b_if.instr, 32'hB000_0002);
        chk("ba8_mis",   b_if.misaligned, 0);
        pc = 12; tick();
        chk("ba12_instr", b_if.instr, 32'hB000_0003);
        pc = 6; tick();
        chk("ba6_instr", b_if.instr, 32'h0);
        chk("ba6_mis",   b_if.misaligned, 1);
        chk("ba6_oob",   b_if.oob, 0);
        pc = 16; tick();
        chk("ba16_oob",   b_if.oob, 1);
        chk("ba16_mis",   b_if.misaligned, 0);
        chk("ba16_valid", b_if.instr_valid, 1);
        fetch_req = 1'b0;

        // asynchronous reset in the middle of a load
        sel = 2'd0;
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 32'h7000_0000 + i;
            tick();
        end
        chk("mid_len_pre", m_if.prog_len, 3);
        reset = 1'b1;
        #2;
        load_valid = 1'b0;
        chk("mid_len",   m_if.prog_len, 0);
        chk("mid_valid", m_if.instr_valid, 0);
        chk("mid_ready", m_if.load_ready, 0);
        chk("mid_state", m_if.state_dbg, ST_EMPTY);
        chk("mid_b_len", b_if.prog_len, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised, runtime-loadable instruction memory for the single-cycle/pipelined CPU. It replaces hard-coded program tables with a RAM filled through a valid/ready load port, then serves registered instruction fetches by PC. Addresses at or beyond the loaded program length return NOP, so no unloaded word is ever visible. It sits between the testbench/program loader and the fetch stage, and supports both word-indexed and byte-addressed PCs.

## Interface

Parameters:
- WIDTH, 32: instruction width in bits.
- DEPTH, 64: number of instruction words; must be ≥ 2.
- PC_WIDTH, 32: PC width in bits.
- BYTE_ADDR, 0: 0 means the PC is a word index; 1 means the PC is a byte address, word index = pc >> 2.
- NOP, 0: WIDTH-bit value returned for OOB, misaligned or unloaded reads.
- Derived: AW = clog2(DEPTH); LW = clog2(DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- load_start  in  1  enter LOAD; clears write pointer, prog_len and load_overflow.
- load_valid  in  1  load word present.
- load_data  in  WIDTH  instruction word to write.
- load_ready  out  1  block accepts a load word.
- load_done  in  1  finish loading; go to RUN.
- fetch_req  in  1  fetch request for pc.
- pc  in  PC_WIDTH  fetch address.
- stall  in  1  freeze fetch outputs.
- instr  out  WIDTH  fetched instruction, registered.
- instr_valid  out  1  instr is valid.
- oob  out  1  the last fetch was at or beyond prog_len.
- misaligned  out  1  the last fetch had pc[1:0] ≠ 0 with BYTE_ADDR = 1; always 0 when BYTE_ADDR = 0.
- prog_len  out  LW  number of words loaded.
- load_overflow  out  1  sticky flag: a load word was offered while full.

## Operation

- States: EMPTY (after reset), LOAD, RUN.
- EMPTY:
  - load_start → LOAD.
  - All other inputs are ignored.
- LOAD:
  - load_ready = (wr_ptr < DEPTH).
  - On a load_valid & load_ready beat: mem[wr_ptr] ← load_data, wr_ptr++, prog_len ← wr_ptr + 1.
  - load_valid while wr_ptr == DEPTH: no write; load_overflow ← 1.
  - load_done → RUN. A beat in the same cycle as load_done is written first.
  - load_start while already in LOAD restarts the load: wr_ptr ← 0, prog_len ← 0, load_overflow ← 0. It takes priority over load_done and load_valid in the same cycle.
  - fetch_req is ignored and instr_valid = 0.
- RUN:
  - load_ready = 0.
  - load_start → LOAD. This clears instr_valid, oob and misaligned the next cycle.
  - On a fetch with fetch_req & !stall:
    - idx = BYTE_ADDR ? pc >> 2 : pc, compared over the full PC_WIDTH (upper bits nonzero means OOB).
    - misaligned fetch: instr ← NOP, misaligned ← 1, oob ← 0.
    - else if idx ≥ prog_len: instr ← NOP, oob ← 1.
    - else: instr ← mem[idx], oob ← 0, misaligned ← 0.
    - In all three cases instr_valid ← 1.
  - With !fetch_req & !stall: instr_valid ← 0; instr, oob and misaligned hold.
  - With stall = 1: instr, instr_valid, oob and misaligned hold, regardless of fetch_req.
- A load of zero words followed by load_done is legal: prog_len = 0 and every fetch is OOB.
- Memory array contents are not reset. Only words below prog_len are ever returned.

## Timing

- Reset (asynchronous) values: state EMPTY, wr_ptr 0, prog_len 0, load_ready 0, instr NOP, instr_valid 0, oob 0, misaligned 0, load_overflow 0.
- load_ready is combinational from state and wr_ptr. It rises the cycle after load_start is sampled.
- Write latency is 1 cycle. A word written at edge N is fetchable once the block is in RUN.
- Fetch latency is 1 cycle: pc is sampled at edge N and instr/instr_valid are valid after edge N.
- Back-to-back fetches give one instruction per cycle.
- load_done sampled at edge N: state is RUN after N, so the first fetch can be sampled at N+1.
- Reset asserted mid-load or mid-fetch: immediate return to reset values. prog_len = 0, so any prior program is invalidated.
- Counters saturate: wr_ptr never exceeds DEPTH and prog_len never exceeds DEPTH.

## Test plan

- Reset and load, then sequential fetch:
  - Stimulus: reset; load_start; 22 beats of words 0x0000_1000+i; load_done; fetch pc 0..21.
  - Required: instr = 0x0000_1000+pc one cycle after each request; instr_valid = 1; prog_len = 22; oob = 0.
- Out of range:
  - Stimulus: after the 22-word load, fetch pc = 22 and pc = 0x8000_0000.
  - Required: instr = NOP, oob = 1, instr_valid = 1 for both.
- Full and overflow, with DEPTH = 4:
  - Stimulus: offer 6 beats.
  - Required: load_ready drops after 4 writes; load_overflow = 1; prog_len = 4.
  - Stimulus: load_start.
  - Required: load_overflow = 0, prog_len = 0.
- Stall and gaps:
  - Stimulus: fetch pc = 3, then stall for 3 cycles while pc changes.
  - Required: instr stays mem[3] and instr_valid stays 1.
  - Stimulus: fetch_req = 0 with stall = 0.
  - Required: instr_valid = 0 next cycle.
- Simultaneous events and reset mid-load:
  - Stimulus: load_valid & load_done in the same cycle.
  - Required: the word is written and state is RUN.
  - Stimulus: load_start & load_done together.
  - Required: state stays LOAD with prog_len = 0.
  - Stimulus: reset after 3 beats.
  - Required: prog_len = 0, instr_valid = 0, load_ready = 0.
- BYTE_ADDR = 1:
  - Stimulus: load 4 words; fetch pc = 8.
  - Required: instr = mem[2].
  - Stimulus: fetch pc = 6.
  - Required: instr = NOP, misaligned = 1.
  - Stimulus: fetch pc = 16.
  - Required: oob = 1.
